// File: rtl/unflatten_if.sv
// Bundles the serial-element input, packed-tensor output and status signals of unflatten.
// The master modport drives elements and consumes the tensor; the slave modport is the unflatten side.
interface unflatten_if #(
  parameter int BITWIDTH = 16,
  parameter int N        = 72
);
  logic                    start;
  logic [BITWIDTH-1:0]     data_in;
  logic                    data_in_valid;
  logic                    data_in_ready;
  logic [BITWIDTH*N-1:0]   data_out;
  logic                    data_out_valid;
  logic                    data_out_ready;
  logic                    done;
  logic                    ovf_err;

  modport master (
    output start, data_in, data_in_valid, data_out_ready,
    input  data_in_ready, data_out, data_out_valid, done, ovf_err
  );

  modport slave (
    input  start, data_in, data_in_valid, data_out_ready,
    output data_in_ready, data_out, data_out_valid, done, ovf_err
  );
endinterface

// File: rtl/unflatten.sv
// Collects N = W*H*C serial elements into one packed tensor and holds it until taken.
// Optional feature: define UNFLATTEN_OVF_FLAG_EN for a sticky flag on elements offered in HOLD.
//
// state | meaning
// IDLE  | waiting for start; data_out keeps the previous tensor
// FILL  | accepting elements into slot cnt_q
// HOLD  | tensor complete, data_out_valid high until data_out_ready
module unflatten #(
  parameter int BITWIDTH    = 16,
  parameter int DATAWIDTH   = 3,
  parameter int DATAHEIGHT  = 3,
  parameter int DATACHANNEL = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clken,
  unflatten_if.slave  bus
);
  localparam int N  = DATAWIDTH * DATAHEIGHT * DATACHANNEL;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BITWIDTH*N-1:0] data_out_q, data_out_d;
  logic                  done_q, done_d;
  logic                  accept;

  assign bus.data_in_ready  = clken & (state_q == FILL);
  assign accept             = bus.data_in_valid & bus.data_in_ready;
  assign bus.data_out       = data_out_q;
  assign bus.data_out_valid = (state_q == HOLD);
  assign bus.done           = done_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_out_d = data_out_q;
    done_d     = done_q;
    if (clken) begin
      done_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_d = FILL;
            cnt_d   = '0;
          end
        end
        FILL: begin
          if (accept) begin
            data_out_d[32'(cnt_q)*BITWIDTH +: BITWIDTH] = bus.data_in;
            // Wrap to 0 on the last element so the counter never exceeds N-1.
            if (cnt_q == LAST) begin
              state_d = HOLD;
              done_d  = 1'b1;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        HOLD: begin
          if (bus.data_out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      data_out_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      done_q     <= done_d;
    end
  end

`ifdef UNFLATTEN_OVF_FLAG_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (clken) begin
      if (state_q == IDLE && bus.start)             ovf_d = 1'b0;
      else if (state_q == HOLD && bus.data_in_valid) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign bus.ovf_err = ovf_q;
`else
  assign bus.ovf_err = 1'b0;
`endif
endmodule

// File: tb/tb_unflatten.sv
// Directed self-checking bench for unflatten (3x3x8 tensor of 16-bit elements).
module tb_unflatten;
  localparam int BW = 16;
  localparam int N  = 72;
`ifdef UNFLATTEN_OVF_FLAG_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clken = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  int   done_cnt = 0;
  logic [BW*N-1:0] exp_vec;

  unflatten_if #(.BITWIDTH(BW), .N(N)) bus ();

  unflatten #(.BITWIDTH(BW), .DATAWIDTH(3), .DATAHEIGHT(3), .DATACHANNEL(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clken (clken),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rst_n && bus.done) done_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.start = 1'b1; bus.data_in = '0; bus.data_in_valid = 1'b1; bus.data_out_ready = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    n_checks++; if (bus.data_in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", bus.data_in_ready); end
    n_checks++; if (bus.data_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", bus.data_out_valid); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", bus.done); end
    n_checks++; if (bus.ovf_err !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b want 0", bus.ovf_err); end
    n_checks++; if (bus.data_out !== '0) begin n_fail++; $display("FAIL rst_data: got nonzero data_out"); end
    bus.start = 1'b0; bus.data_in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    n_checks++; if (bus.data_in_ready !== 1'b0) begin n_fail++; $display("FAIL idle_ready: got %b want 0", bus.data_in_ready); end
  endtask

  task automatic test_basic();
    done_cnt = 0;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    n_checks++; if (bus.data_in_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready: got %b want 1", bus.data_in_ready); end
    for (int k = 0; k < N; k++) begin
      bus.data_in = BW'(k); bus.data_in_valid = 1'b1;
      if (k == N-1) begin
        n_checks++; if (bus.data_out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b want 0", bus.data_out_valid); end
      end
      tick();
    end
    bus.data_in_valid = 1'b0;
    n_checks++; if (bus.data_out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency_valid: got %b want 1", bus.data_out_valid); end
    n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL basic_done: got %b want 1", bus.done); end
    tick();
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL basic_done_width: got %b want 0", bus.done); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL basic_done_count: got %0d want 1", done_cnt); end
    for (int k = 0; k < N; k++) begin
      n_checks++;
      if (bus.data_out[k*BW +: BW] !== BW'(k)) begin n_fail++; $display("FAIL basic_slot%0d: got %h want %h", k, bus.data_out[k*BW +: BW], BW'(k)); end
    end
    bus.data_out_ready = 1'b1; tick(); bus.data_out_ready = 1'b0;
    n_checks++; if (bus.data_out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_release: got %b want 0", bus.data_out_valid); end
    n_checks++; if (bus.data_in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_idle_ready: got %b want 0", bus.data_in_ready); end
  endtask

  task automatic test_gaps();
    done_cnt = 0;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (k % 5 == 3) begin
        bus.data_in = 16'hBEEF; bus.data_in_valid = 1'b0; tick();
      end
      if (k == 40) begin
        clken = 1'b0; bus.data_in = 16'hDEAD; bus.data_in_valid = 1'b1;
        for (int g = 0; g < 5; g++) begin
          tick();
          n_checks++; if (bus.data_in_ready !== 1'b0) begin n_fail++; $display("FAIL gap_ready: got %b want 0", bus.data_in_ready); end
          n_checks++; if (bus.data_out[40*BW +: BW] !== 16'd40) begin n_fail++; $display("FAIL gap_slot40: got %h want 0028", bus.data_out[40*BW +: BW]); end
        end
        clken = 1'b1;
      end
      bus.data_in = 16'h0100 + BW'(k); bus.data_in_valid = 1'b1;
      tick();
    end
    bus.data_in_valid = 1'b0;
    n_checks++; if (bus.data_out_valid !== 1'b1) begin n_fail++; $display("FAIL gaps_valid: got %b want 1", bus.data_out_valid); end
    for (int k = 0; k < N; k++) begin
      exp_vec[k*BW +: BW] = 16'h0100 + BW'(k);
      n_checks++;
      if (bus.data_out[k*BW +: BW] !== exp_vec[k*BW +: BW]) begin n_fail++; $display("FAIL gaps_slot%0d: got %h want %h", k, bus.data_out[k*BW +: BW], exp_vec[k*BW +: BW]); end
    end
    tick();
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL gaps_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_hold();
    bus.data_out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      bus.data_in_valid = (c >= 2 && c <= 4);
      bus.data_in = 16'h7777;
      bus.start = (c == 6);
      tick();
      n_checks++; if (bus.data_out !== exp_vec) begin n_fail++; $display("FAIL hold_stable%0d: data_out changed", c); end
      n_checks++; if (bus.data_out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid%0d: got %b want 1", c, bus.data_out_valid); end
      n_checks++; if (bus.data_in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_ready%0d: got %b want 0", c, bus.data_in_ready); end
    end
    bus.data_in_valid = 1'b0; bus.start = 1'b0;
    n_checks++; if (bus.ovf_err !== OVF_EXP) begin n_fail++; $display("FAIL hold_ovf: got %b want %b", bus.ovf_err, OVF_EXP); end
    bus.data_out_ready = 1'b1; tick(); bus.data_out_ready = 1'b0;
    n_checks++; if (bus.data_out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release: got %b want 0", bus.data_out_valid); end
    tick();
    n_checks++; if (bus.data_in_ready !== 1'b0) begin n_fail++; $display("FAIL idle2_ready: got %b want 0", bus.data_in_ready); end
    n_checks++; if (bus.data_out !== exp_vec) begin n_fail++; $display("FAIL idle_retain: data_out not retained"); end
    n_checks++; if (bus.ovf_err !== OVF_EXP) begin n_fail++; $display("FAIL idle_ovf_sticky: got %b want %b", bus.ovf_err, OVF_EXP); end
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    n_checks++; if (bus.ovf_err !== 1'b0) begin n_fail++; $display("FAIL start_ovf_clear: got %b want 0", bus.ovf_err); end
  endtask

  task automatic test_reset_midfill();
    for (int k = 0; k < 30; k++) begin
      bus.data_in = 16'h0200 + BW'(k); bus.data_in_valid = 1'b1; tick();
    end
    n_checks++; if (bus.data_out[5*BW +: BW] !== 16'h0205) begin n_fail++; $display("FAIL partial_slot5: got %h want 0205", bus.data_out[5*BW +: BW]); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.data_out !== '0) begin n_fail++; $display("FAIL midrst_data: got nonzero data_out"); end
    n_checks++; if (bus.data_in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready: got %b want 0", bus.data_in_ready); end
    n_checks++; if (bus.data_out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", bus.data_out_valid); end
    tick();
    rst_n = 1'b1;
    bus.data_in = 16'h5555; bus.data_in_valid = 1'b1;
    tick(); tick();
    n_checks++; if (bus.data_in_ready !== 1'b0) begin n_fail++; $display("FAIL postrst_ready: got %b want 0", bus.data_in_ready); end
    done_cnt = 0;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    for (int k = 0; k < N; k++) begin
      bus.data_in = 16'hAAAA; bus.data_in_valid = 1'b1; tick();
    end
    bus.data_in_valid = 1'b0;
    tick();
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL aaaa_done_count: got %0d want 1", done_cnt); end
    n_checks++; if (bus.data_out_valid !== 1'b1) begin n_fail++; $display("FAIL aaaa_valid: got %b want 1", bus.data_out_valid); end
    for (int k = 0; k < N; k++) begin
      n_checks++;
      if (bus.data_out[k*BW +: BW] !== 16'hAAAA) begin n_fail++; $display("FAIL aaaa_slot%0d: got %h want aaaa", k, bus.data_out[k*BW +: BW]); end
    end
    bus.data_in_valid = 1'b1; tick(); bus.data_in_valid = 1'b0;
    n_checks++; if (bus.ovf_err !== OVF_EXP) begin n_fail++; $display("FAIL aaaa_ovf: got %b want %b", bus.ovf_err, OVF_EXP); end
  endtask

  initial begin
    bus.start = 1'b0; bus.data_in = '0; bus.data_in_valid = 1'b0; bus.data_out_ready = 1'b0;
    exp_vec = '0;
    test_reset();
    test_basic();
    test_gaps();
    test_hold();
    test_reset_midfill();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/unflatten.md
UNFLATTEN -- requirements
Module: unflatten

Interface
REQ-001 SHALL have parameter BITWIDTH, default 16: element width in bits.
REQ-002 SHALL have parameter DATAWIDTH, default 3: tensor width W.
REQ-003 SHALL have parameter DATAHEIGHT, default 3: tensor height H.
REQ-004 SHALL have parameter DATACHANNEL, default 8: tensor channels C; N = W*H*C elements.
REQ-005 SHALL have port clk  input  1: the only clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n  input  1: reset, asynchronous and active-low.
REQ-007 SHALL have port clken  input  1: clock enable; when low, all state holds.
REQ-008 SHALL have port start  input  1: begins a new tensor fill.
REQ-009 SHALL have port data_in  input  BITWIDTH: serial element.
REQ-010 SHALL have port data_in_valid  input  1: data_in carries an element.
REQ-011 SHALL have port data_in_ready  output  1: block accepts an element this cycle.
REQ-012 SHALL have port data_out  output  BITWIDTH*N: packed tensor.
REQ-013 SHALL have port data_out_valid  output  1: data_out is complete.
REQ-014 SHALL have port data_out_ready  input  1: consumer takes data_out.
REQ-015 SHALL have port done  output  1: one-cycle pulse when the tensor completes.
REQ-016 SHALL have port ovf_err  output  1: sticky overflow flag (see Configuration).

Function
REQ-017 SHALL implement FSM states IDLE, FILL, HOLD; transitions occur only when clken=1.
REQ-018 IDLE: start=1 -> FILL, element counter cleared to 0; start outside IDLE is ignored.
REQ-019 data_in_ready SHALL be combinational: clken AND (state==FILL).
REQ-020 Element accepted when data_in_valid AND data_in_ready; element k SHALL be written to data_out[k*BITWIDTH +: BITWIDTH], k = (c*H+h)*W+w, counter incremented.
REQ-021 Accepting element k=N-1 SHALL move FILL->HOLD; data_out_valid=1 and done=1 on the next cycle, so latency is 1 cycle from the last accept.
REQ-022 done SHALL be high exactly one clken-qualified cycle per tensor.
REQ-023 HOLD: data_out_valid=1 and data_out stable; data_out_ready=1 -> IDLE, with data_out_valid low the following cycle.
REQ-024 data_out SHALL retain its last contents after HOLD until overwritten element by element in the next fill.
REQ-025 Elements presented while not ready SHALL be dropped without effect on data_out or the counter.
REQ-026 clken=0 mid-FILL SHALL freeze the counter and contents; the fill resumes when clken returns high.
REQ-027 Counter width SHALL be clog2(N) bits, and the counter SHALL never exceed N-1.

Reset
REQ-028 rst_n low SHALL immediately force state=IDLE, counter=0, data_out=0, data_out_valid=0, done=0, ovf_err=0.
REQ-029 data_in_ready SHALL be 0 during reset.
REQ-030 Reset mid-FILL or mid-HOLD SHALL discard the partial tensor; operation requires a new start.

Configuration
REQ-031 Macro UNFLATTEN_OVF_FLAG_EN defined: ovf_err SHALL set when data_in_valid=1 in HOLD with clken=1, and clear only on reset or on start in IDLE.
REQ-032 UNFLATTEN_OVF_FLAG_EN undefined: ovf_err SHALL be driven constant 0; all other behaviour is identical.

Verification
REQ-033 Reset, then start, then 72 elements with values 0..71 and valid held high -> data_out slot k = k, done pulses once, data_out_valid rises 1 cycle after the 72nd accept.
REQ-034 Random valid gaps and clken=0 for 5 cycles mid-fill -> the same packed result; the counter holds during the gap.
REQ-035 HOLD with data_out_ready=0 for 10 cycles, then 1 -> data_out stable throughout, IDLE next cycle, data_in_ready=0 in HOLD and IDLE.
REQ-036 rst_n pulsed low after 30 elements -> all outputs 0 immediately; a new start followed by 72 elements of value 0xAAAA -> all slots equal 0xAAAA.
REQ-037 With UNFLATTEN_OVF_FLAG_EN defined, data_in_valid=1 in HOLD -> ovf_err=1 until the next start in IDLE; with the macro undefined, ovf_err stays 0.
